// File: rtl/counter_readout_ctrl.sv
// Counter readout sequencer.
// When a dump is requested, this block waits until the system reports IDLE.
// It then walks the counter block through indices 0..NUM_CNT-1, one index at a time.
// Each returned value is latched and presented under a valid/ready handshake.
// A running total of the captured values is kept in sum.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no dump active; may hold a deferred start in pend
//   ST_REQ  | req high for cur_idx, waiting for cnt_valid (with timeout)
//   ST_OUT  | captured value held on out_*, waiting for out_ready
//   ST_DONE | one-cycle done pulse after the last value was accepted
module counter_readout_ctrl #(
    parameter int NUM_CNT = 5,
    parameter int DATA_W  = 5,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    IDLE,
    input  logic                    cnt_valid,
    input  logic [DATA_W-1:0]       cnt_data,
    output logic                    req,
    output logic [IDX_W-1:0]        idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic [DATA_W+IDX_W-1:0] sum,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t            state;
    logic              pend;
    logic [IDX_W-1:0]  cur_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;

    // Sequencer: state, index walk, capture/handshake registers, sum and timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pend      <= 1'b0;
            cur_idx   <= '0;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            sum       <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A start seen while the system is busy is remembered in pend
                    // and is launched as soon as IDLE rises.
                    if ((start || pend) && IDLE) begin
                        state    <= ST_REQ;
                        cur_idx  <= '0;
                        sum      <= '0;
                        pend     <= 1'b0;
                        wait_cnt <= '0;
                    end else if (start) begin
                        pend <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (cnt_valid) begin
                        out_data  <= cnt_data;
                        out_idx   <= cur_idx;
                        out_valid <= 1'b1;
                        sum       <= sum + {{IDX_W{1'b0}}, cnt_data};
                        wait_cnt  <= '0;
                        state     <= ST_OUT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Abort the dump; the last captured value and sum stay visible.
                        err_q    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (cur_idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            cur_idx <= cur_idx + IDX_W'(1);
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs decode directly from registered state.
    assign req  = (state == ST_REQ);
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign err  = err_q;
    assign idx  = cur_idx;

endmodule

// File: tb/tb_counter_readout_ctrl.sv
// Directed bench for counter_readout_ctrl.
// It contains a behavioural counter block that answers req combinationally while IDLE=1.
module tb_counter_readout_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       IDLE;
    logic       cnt_valid;
    logic [4:0] cnt_data;
    logic       req;
    logic [2:0] idx;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic [2:0] out_idx;
    logic [7:0] sum;
    logic       busy;
    logic       done;
    logic       err;

    logic [4:0] cnt_mem [8];

    int checks   = 0;
    int failures = 0;

    counter_readout_ctrl #(
        .NUM_CNT(5), .DATA_W(5), .IDX_W(3), .TIMEOUT(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .IDLE      (IDLE),
        .cnt_valid (cnt_valid),
        .cnt_data  (cnt_data),
        .req       (req),
        .idx       (idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .sum       (sum),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    assign cnt_valid = req && IDLE;
    assign cnt_data  = cnt_mem[idx];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_counters(input int c0, input int c1, input int c2, input int c3, input int c4);
        for (int i = 0; i < 8; i++) cnt_mem[i] = 5'd0;
        cnt_mem[0] = 5'(c0);
        cnt_mem[1] = 5'(c1);
        cnt_mem[2] = 5'(c2);
        cnt_mem[3] = 5'(c3);
        cnt_mem[4] = 5'(c4);
    endtask

    // Called in the REQ cycle of index k; leaves the bench in the following REQ or DONE cycle.
    task automatic do_index(input int k, input int d);
        chk($sformatf("req_hi_%0d", k), 32'(req), 1);
        chk($sformatf("idx_%0d", k), 32'(idx), 32'(k));
        chk($sformatf("ov_lo_in_req_%0d", k), 32'(out_valid), 0);
        tick();
        chk($sformatf("ov_hi_%0d", k), 32'(out_valid), 1);
        chk($sformatf("odata_%0d", k), 32'(out_data), 32'(d));
        chk($sformatf("oidx_%0d", k), 32'(out_idx), 32'(k));
        chk($sformatf("req_lo_in_out_%0d", k), 32'(req), 0);
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(req), 0);
        chk({tag, "_idx"}, 32'(idx), 0);
        chk({tag, "_ov"}, 32'(out_valid), 0);
        chk({tag, "_odata"}, 32'(out_data), 0);
        chk({tag, "_oidx"}, 32'(out_idx), 0);
        chk({tag, "_sum"}, 32'(sum), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        IDLE      = 1'b1;
        out_ready = 1'b1;
        set_counters(3, 0, 7, 31, 1);

        // Test 1: reset, then a back-to-back dump with out_ready=1.
        tick();
        tick();
        chk_all_zero("rst");
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        do_index(0, 3);
        do_index(1, 0);
        do_index(2, 7);
        do_index(3, 31);
        do_index(4, 1);
        chk("t1_done_c11", 32'(done), 1);
        chk("t1_sum", 32'(sum), 42);
        tick();
        chk("t1_done_lo", 32'(done), 0);
        chk("t1_busy_lo", 32'(busy), 0);
        chk("t1_sum_hold", 32'(sum), 42);

        // Test 2: start is deferred while IDLE=0.
        IDLE  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_no_req", 32'(req), 0);
            chk("t2_no_busy", 32'(busy), 0);
            tick();
        end
        IDLE = 1'b1;
        tick();
        chk("t2_sum_clr", 32'(sum), 0);
        do_index(0, 3);
        do_index(1, 0);
        do_index(2, 7);
        do_index(3, 31);
        do_index(4, 1);
        chk("t2_done", 32'(done), 1);
        chk("t2_err", 32'(err), 0);
        chk("t2_sum", 32'(sum), 42);
        tick();

        // Test 3: consumer stalls on index 2.
        start = 1'b1;
        tick();
        start = 1'b0;
        do_index(0, 3);
        do_index(1, 0);
        chk("t3_req2", 32'(req), 1);
        chk("t3_idx2", 32'(idx), 2);
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t3_stall_ov", 32'(out_valid), 1);
            chk("t3_stall_data", 32'(out_data), 7);
            chk("t3_stall_oidx", 32'(out_idx), 2);
            chk("t3_stall_req", 32'(req), 0);
            chk("t3_stall_idx", 32'(idx), 2);
            tick();
        end
        chk("t3_still_ov", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        do_index(3, 31);
        do_index(4, 1);
        chk("t3_done", 32'(done), 1);
        chk("t3_sum", 32'(sum), 42);
        tick();

        // Test 4: IDLE drops during REQ of index 1 -> timeout abort after 16 cycles.
        start = 1'b1;
        tick();
        start = 1'b0;
        do_index(0, 3);
        IDLE = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("t4_req_wait", 32'(req), 1);
            chk("t4_err_lo", 32'(err), 0);
            tick();
        end
        chk("t4_err_hi", 32'(err), 1);
        chk("t4_busy_lo", 32'(busy), 0);
        chk("t4_done_lo", 32'(done), 0);
        chk("t4_sum_keep", 32'(sum), 3);
        chk("t4_odata_keep", 32'(out_data), 3);
        tick();
        chk("t4_err_pulse", 32'(err), 0);
        for (int i = 0; i < 3; i++) begin
            chk("t4_quiet_done", 32'(done), 0);
            chk("t4_quiet_req", 32'(req), 0);
            tick();
        end
        IDLE  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_redo_sum0", 32'(sum), 0);
        do_index(0, 3);
        do_index(1, 0);
        do_index(2, 7);
        do_index(3, 31);
        do_index(4, 1);
        chk("t4_redo_done", 32'(done), 1);
        chk("t4_redo_sum", 32'(sum), 42);
        tick();

        // Test 5: reset while in OUT of index 3.
        start = 1'b1;
        tick();
        start = 1'b0;
        do_index(0, 3);
        do_index(1, 0);
        do_index(2, 7);
        chk("t5_req3", 32'(req), 1);
        tick();
        chk("t5_in_out3", 32'(out_valid), 1);
        reset = 1'b1;
        tick();
        chk_all_zero("t5_rst");
        reset = 1'b0;
        tick();
        chk("t5_idle_after", 32'(busy), 0);

        // Test 6: all counters max, start pulses while busy are ignored.
        set_counters(31, 31, 31, 31, 31);
        start = 1'b1;
        tick();
        start = 1'b0;
        do_index(0, 31);
        do_index(1, 31);
        start = 1'b1;
        do_index(2, 31);
        start = 1'b0;
        do_index(3, 31);
        do_index(4, 31);
        chk("t6_done", 32'(done), 1);
        chk("t6_sum", 32'(sum), 155);
        tick();
        chk("t6_done_width", 32'(done), 0);
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_redump", 32'(busy), 0);
            chk("t6_sum_hold", 32'(sum), 155);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_readout_ctrl.md
Name: counter_readout_ctrl

Overview:
- Sequencer that dumps the per-FIFO pop counters of the counter block to a downstream consumer.
- On a start request it waits for system IDLE, then drives req/idx through indices 0..NUM_CNT-1, one at a time.
- Captures each counter value into an output register, holds it under a valid/ready handshake, and accumulates a total sum.
- Sits between the system control FSM (start, IDLE) and the counter block (req, idx, valid, data_out).

Parameters:
NUM_CNT, 5, number of counters to read; indices 0..NUM_CNT-1.
DATA_W, 5, counter value width.
IDX_W, 3, index width; must satisfy 2^IDX_W >= NUM_CNT.
TIMEOUT, 16, max cycles in REQ without cnt_valid before abort; must be at least 1.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle dump request.
IDLE  input  1  system idle indication; the counter block answers only while IDLE=1.
cnt_valid  input  1  valid from the counter block; combinational response to req in the same cycle.
cnt_data  input  DATA_W  counter value from the counter block.
req  output  1  read request to the counter block.
idx  output  IDX_W  counter index for the current read.
out_valid  output  1  out_data and out_idx hold a captured value.
out_ready  input  1  consumer accepts while out_valid=1.
out_data  output  DATA_W  captured counter value.
out_idx  output  IDX_W  index of out_data.
sum  output  DATA_W+IDX_W  running total of the counters captured in this dump.
busy  output  1  high in every state except ST_IDLE.
done  output  1  one-cycle pulse after the last value is accepted.
err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (reset=1 at a clock edge):
  - state=ST_IDLE; pend=0; cur_idx=0; wait_cnt=0.
  - All outputs 0, including sum, out_data and out_idx.
  - Reset has priority over every other input and aborts any dump in progress.
- States: ST_IDLE, ST_REQ, ST_OUT, ST_DONE. State and all outputs are registered; req, busy, done and err decode from state and flags.
- ST_IDLE:
  - start=1 and IDLE=1: go to ST_REQ; cur_idx=0; sum=0; pend=0.
  - start=1 and IDLE=0: set pend=1 and stay.
  - pend=1 and IDLE=1: go to ST_REQ, same actions as a direct start.
  - A start arriving while pend=1 has no further effect.
- ST_REQ:
  - req=1, idx=cur_idx.
  - cnt_valid=1 at an edge:
    - out_data<=cnt_data; out_idx<=cur_idx; out_valid<=1.
    - sum<=sum+cnt_data, zero-extended, no overflow possible.
    - wait_cnt<=0; go to ST_OUT.
  - cnt_valid=0 (for example, IDLE dropped): stay, hold idx, wait_cnt++.
  - wait_cnt reaching TIMEOUT-1 with cnt_valid=0: err pulse next cycle, go to ST_IDLE. sum, out_data and out_idx keep their last values; no done pulse.
- ST_OUT:
  - req=0; out_valid, out_data and out_idx are held stable until out_ready=1.
  - out_ready=1 at an edge: out_valid<=0.
    - cur_idx==NUM_CNT-1: go to ST_DONE.
    - Otherwise: cur_idx++ and go to ST_REQ.
- ST_DONE: done=1 for exactly one cycle, then go to ST_IDLE. sum stays valid until the next dump starts.
- start while busy=1: ignored, pend is not set.
- Latency with out_ready tied high and IDLE=1:
  - start sampled at edge 0.
  - req high during cycles 1,3,5,7,9.
  - out_valid high during cycles 2,4,6,8,10.
  - done high during cycle 11.
- req and out_valid are never high in the same cycle.
- idx only changes while req=0.

Test Plan:
1. reset=1 for 2 cycles, then start with IDLE=1, out_ready=1, counters {3,0,7,31,1} -> out_data sequence 3,0,7,31,1 with out_idx 0..4; sum=42; done high in cycle 11 after start.
2. start with IDLE=0, IDLE rises 5 cycles later -> req first high 1 cycle after IDLE rises; no err; dump completes normally.
3. out_ready low for 4 cycles on index 2 -> out_valid, out_data and out_idx stay stable for those 4 cycles; req stays 0; idx 3 is read only after acceptance.
4. IDLE drops during ST_REQ of index 1 for 20 cycles with TIMEOUT=16 -> err pulses once; busy=0; done never asserts; a following start redoes the dump from idx 0 with sum reset.
5. reset=1 while in ST_OUT of index 3 -> next cycle state ST_IDLE, all outputs 0; start pulses during busy otherwise produce no extra dump.
6. Counters all 31 -> sum=155, no overflow of the 8-bit sum; done pulse exactly 1 cycle wide.
